s_aes128_key_schedule: RTL
==========================

Name: s_aes128_key_schedule

Overview:
Iterative AES-128 key expansion stage that sits directly upstream of the single-round AES datapath. It drives that datapath's Key input with one 128-bit round key per handshake. The cipher key is loaded on start. Round keys 0..NUM_ROUNDS are produced sequentially, one SubWord/RotWord/Rcon step per accepted key. A valid/ready handshake lets the round controller stall the schedule.

Parameters:
NUM_ROUNDS, 10, index of the last round key emitted; legal range 1..10, limited by the Rcon table depth.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request to begin expansion of key_in; sampled only in IDLE.
key_in  input  128  cipher key; byte 0 = key_in[127:120]; w0 = key_in[127:96].
rk_ready  input  1  consumer accepts rk_out on a clock edge where rk_valid=1 and rk_ready=1.
rk_valid  output  1  rk_out/rk_index hold a valid round key.
rk_out  output  128  current round key, same byte order as key_in.
rk_index  output  4  round number of rk_out, 0..NUM_ROUNDS.
busy  output  1  high from the edge after accepted start until the final key is accepted.
done  output  1  one-cycle pulse on the edge the final round key (index NUM_ROUNDS) is accepted.

Behaviour:
- Reset (rst=1 at clock edge) forces IDLE and clears all outputs:
  - rk_valid=0, rk_out=0, rk_index=0, busy=0, done=0.
  - Internal Rcon index and key register are cleared.
  - Reset mid-expansion abandons the sequence; no done is issued.
- States: IDLE, EMIT.
- IDLE, start=1:
  - Next edge: rk_out<=key_in, rk_index<=0, rk_valid<=1, busy<=1, go to EMIT.
  - Latency from start to first valid key is 1 cycle.
- IDLE, start=0: outputs hold; rk_valid=0.
- EMIT, rk_ready=0: rk_out, rk_index and rk_valid hold stable. This is a stall of unbounded length.
- EMIT, rk_ready=1 and rk_index<NUM_ROUNDS:
  - Next key is computed combinationally from the current rk_out = {w0,w1,w2,w3}.
  - t = SubWord(RotWord(w3)) ^ {Rcon[rk_index+1],24'h0}.
  - RotWord(w) = {w[23:0],w[31:24]}.
  - SubWord applies the AES forward S-box to each byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - rk_out<={n0,n1,n2,n3}, rk_index<=rk_index+1, rk_valid stays 1.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex).
- EMIT, rk_ready=1 and rk_index==NUM_ROUNDS:
  - Next edge: rk_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
  - rk_out and rk_index retain the last values.
- start while busy is ignored; the key in progress is not disturbed.
- start asserted in the same cycle done pulses (state already IDLE next cycle) is accepted normally. Back-to-back expansions therefore have a 1-cycle gap with rk_valid=0.
- With rk_ready held high: key k is valid in cycle t+1+k, and done pulses in cycle t+2+NUM_ROUNDS.
- rst has priority over start and rk_ready in the same cycle.
- No combinational path from rk_ready to rk_valid or rk_out. All outputs are registered.

Test Plan:
- FIPS-197 vector, rk_ready=1: key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse.
  - Index0 = same key.
  - Index1 = a0fafe1788542cb123a339392a6c7605.
  - Index2 = f2c295f27a96b9435935807a7359f67f.
  - Index10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done exactly one cycle after index10 is accepted.
- Backpressure: same key, rk_ready toggled randomly.
  - rk_out and rk_index never change while rk_valid=1 and rk_ready=0.
  - The same 11 keys arrive in order.
- Ignored start: pulse start with key 000...0 while index=4 is pending.
  - The sequence continues with FIPS keys.
  - busy stays 1 throughout.
- Reset mid-operation: assert rst while index=6 is pending.
  - Next cycle: rk_valid=0, busy=0, rk_index=0, rk_out=0, no done.
  - A new start yields index0 one cycle later.
- All-zero key: key_in=0.
  - Index1 = 62636363626363636263636362636363.
  - Index10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- NUM_ROUNDS=1 build: after index1 is accepted, done pulses and busy drops. Issuing start in the done cycle restarts with a 1-cycle rk_valid gap.

Source files
------------

// File: rtl/s_aes128_key_schedule.sv
// Iterative AES-128 key expansion: emits round keys 0..NUM_ROUNDS one per
// valid/ready handshake, computing the next key from the one currently held.
module s_aes128_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];
endmodule

module s_aes128_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  logic [3:0][7:0]  rot, sub;
  logic [31:0]      t;
  logic [3:0][31:0] w, n;

  assign w   = rk_out;
  assign rot = {w[0][23:0], w[0][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sub
    s_aes128_sbox u_sbox (.a(rot[g]), .y(sub[g]));
  end

  // w[3] is the most significant word (w0 of the round key), w[0] is w3.
  assign t    = sub ^ {rcon(rk_index + 4'd1), 24'h0};
  assign n[3] = w[3] ^ t;
  assign n[2] = w[2] ^ n[3];
  assign n[1] = w[1] ^ n[2];
  assign n[0] = w[0] ^ n[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_index <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rk_out   <= key_in;
          rk_index <= '0;
          rk_valid <= 1'b1;
          busy     <= 1'b1;
          state    <= EMIT;
        end
        EMIT: if (rk_ready) begin
          if (rk_index == 4'(NUM_ROUNDS)) begin
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            rk_out   <= n;
            rk_index <= rk_index + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
